entity_line_scanner: RTL and testbench
======================================

ENTITY_LINE_SCANNER -- requirements
Module: entity_line_scanner

Interface
REQ-001 Parameter SIZE, default 48, entity edge length in pixels for the vertical hit test.
REQ-002 Parameter MAX_HITS, default 16, maximum hits forwarded per scan (1..31).
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 line_start  input  1  one-cycle pulse: begin a scan for line_y.
REQ-006 line_y  input  9  scanline, sampled only when line_start=1.
REQ-007 entities_number  input  8  table entry count, sampled when line_start=1.
REQ-008 address_read_ent  output  8  entity table read address.
REQ-009 data_read_ent  input  21  {type[20:18], x[17:9], y[8:0]}, valid one cycle after the address.
REQ-010 hit_valid  output  1  hit_data holds a matching entity.
REQ-011 hit_data  output  21  matching entity word, unmodified.
REQ-012 hit_ready  input  1  consumer accepts hit_data when hit_valid=1 and hit_ready=1.
REQ-013 scan_busy  output  1  scan in progress.
REQ-014 scan_done  output  1  one-cycle pulse at normal scan completion.
REQ-015 hit_count  output  5  hits accepted into hit_data this scan, saturating at MAX_HITS.
REQ-016 overflow  output  1  a hit was dropped because hit_count had reached MAX_HITS.

Function
REQ-017 States SHALL be IDLE, FETCH, EVAL, WAIT, DONE.
REQ-018 IDLE: on line_start, latch line_y and entities_number, set address_read_ent=0, clear hit_count and overflow, go to FETCH; if latched entities_number=0, go to DONE instead.
REQ-019 FETCH: drive address_read_ent for one cycle, go to EVAL (accounts for the one-cycle read latency).
REQ-020 EVAL: hit SHALL be y <= line_y < y+SIZE, with y+SIZE computed at 10 bits (no wrap).
REQ-021 EVAL, hit, hit_count<MAX_HITS, output register free or being consumed this cycle: load hit_data, set hit_valid, increment hit_count.
REQ-022 EVAL, hit, hit_count<MAX_HITS, output register occupied and hit_ready=0: go to WAIT, holding address_read_ent so data_read_ent stays valid.
REQ-023 EVAL, hit, hit_count=MAX_HITS: drop the entity, set overflow (sticky until next line_start).
REQ-024 WAIT: when hit_ready=1, perform the REQ-021 load and leave WAIT as EVAL would.
REQ-025 Leaving EVAL/WAIT: if address_read_ent = latched count-1, go to DONE; else increment address, go to FETCH.
REQ-026 DONE: pulse scan_done for one cycle, go to IDLE; hit_valid/hit_data persist until consumed.
REQ-027 hit_data SHALL remain stable while hit_valid=1 and hit_ready=0.
REQ-028 scan_busy SHALL be 1 in FETCH, EVAL, WAIT, 0 in IDLE and DONE.
REQ-029 line_start while not IDLE SHALL abort: clear hit_valid, restart per REQ-018 on the same edge; no scan_done for the aborted scan.
REQ-030 Throughput: exactly 2 cycles per entity when hit_ready stays 1; 114 entities complete within 230 cycles of line_start.

Reset
REQ-031 rst=1 SHALL force IDLE, address_read_ent=0, hit_valid=0, hit_data=0, scan_busy=0, scan_done=0, hit_count=0, overflow=0, overriding line_start in the same cycle.

Verification
REQ-032 114-entry 48-pixel grid table, line_y=100, hit_ready=1 -> hits are exactly the entries with y=96 in ascending address order, scan_done 229 cycles after line_start, overflow=0.
REQ-033 Same table, line_y=47, hit_ready=0 for 20 cycles after first hit -> FSM holds in WAIT, hit_data stable at first hit {type,x,y=0}, remaining hits delivered after release, none lost.
REQ-034 Entries with y=0 on line_y=0 and line_y=47 -> hit; line_y=48 -> no hit; y=432, line_y=479 -> hit (no 9-bit wrap).
REQ-035 MAX_HITS=4, 10 matching entries -> hit_count=4, overflow=1, exactly 4 handshakes.
REQ-036 line_start mid-scan at entry 30 -> hit_valid cleared, address returns to 0, single scan_done for the new scan only; entities_number=0 -> scan_done next cycle, no hits.
REQ-037 rst asserted in WAIT with hit_valid=1 -> all outputs at REQ-031 values next cycle.

Source files
------------

// File: rtl/entity_line_scanner_if.sv
// Bundle for the scanline request, the entity table read port and the hit stream.
// The master drives requests and table data. The slave is the scanner.
interface entity_line_scanner_if;
    logic        line_start;
    logic [8:0]  line_y;
    logic [7:0]  entities_number;
    logic [7:0]  address_read_ent;
    logic [20:0] data_read_ent;
    logic        hit_valid;
    logic [20:0] hit_data;
    logic        hit_ready;
    logic        scan_busy;
    logic        scan_done;
    logic [4:0]  hit_count;
    logic        overflow;

    modport master (
        output line_start, line_y, entities_number, data_read_ent, hit_ready,
        input  address_read_ent, hit_valid, hit_data, scan_busy, scan_done, hit_count, overflow
    );

    modport slave (
        input  line_start, line_y, entities_number, data_read_ent, hit_ready,
        output address_read_ent, hit_valid, hit_data, scan_busy, scan_done, hit_count, overflow
    );
endinterface

// File: rtl/entity_line_scanner.sv
// Walks the entity table for one scanline and forwards each entity whose vertical span
// covers that line. The entities are sent through a single-entry valid/ready output register.
module entity_line_scanner #(
    parameter int SIZE     = 48,
    parameter int MAX_HITS = 16
) (
    input logic                  clk,
    input logic                  rst,
    entity_line_scanner_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, EVAL, WAIT, DONE} state_t;

    localparam logic [9:0] SIZE_W = 10'(SIZE);
    localparam logic [4:0] MAX_W  = 5'(MAX_HITS);

    state_t      state_q, state_d;
    logic [8:0]  line_y_q, line_y_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  addr_q, addr_d;
    logic        hit_valid_q, hit_valid_d;
    logic [20:0] hit_data_q, hit_data_d;
    logic [4:0]  hit_count_q, hit_count_d;
    logic        overflow_q, overflow_d;

    logic [8:0]  ent_y;
    logic [9:0]  y_end;
    logic        is_hit;
    logic        out_free;
    logic        last_entry;
    logic        load;
    logic        advance;

    always_comb begin
        state_d     = state_q;
        line_y_d    = line_y_q;
        count_d     = count_q;
        addr_d      = addr_q;
        hit_valid_d = hit_valid_q;
        hit_data_d  = hit_data_q;
        hit_count_d = hit_count_q;
        overflow_d  = overflow_q;
        load        = 1'b0;
        advance     = 1'b0;

        // The span end is formed at 10 bits so entities near the bottom of the screen do not wrap.
        ent_y      = bus.data_read_ent[8:0];
        y_end      = {1'b0, ent_y} + SIZE_W;
        is_hit     = (ent_y <= line_y_q) && ({1'b0, line_y_q} < y_end);
        out_free   = !hit_valid_q || bus.hit_ready;
        last_entry = (addr_q == count_q - 8'd1);

        if (hit_valid_q && bus.hit_ready) begin
            hit_valid_d = 1'b0;
        end

        case (state_q)
            IDLE:  ;
            FETCH: state_d = EVAL;
            EVAL: begin
                if (!is_hit) begin
                    advance = 1'b1;
                end else if (hit_count_q == MAX_W) begin
                    overflow_d = 1'b1;
                    advance    = 1'b1;
                end else if (out_free) begin
                    load    = 1'b1;
                    advance = 1'b1;
                end else begin
                    // Address stays put so the table keeps presenting this entity.
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.hit_ready) begin
                    load    = 1'b1;
                    advance = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (load) begin
            hit_data_d  = bus.data_read_ent;
            hit_valid_d = 1'b1;
            hit_count_d = hit_count_q + 5'd1;
        end

        if (advance) begin
            if (last_entry) begin
                state_d = DONE;
            end else begin
                addr_d  = addr_q + 8'd1;
                state_d = FETCH;
            end
        end

        // A new request always wins; outside IDLE it aborts the running scan and its pending hit.
        if (bus.line_start) begin
            if (state_q != IDLE) begin
                hit_valid_d = 1'b0;
            end
            line_y_d    = bus.line_y;
            count_d     = bus.entities_number;
            addr_d      = 8'd0;
            hit_count_d = 5'd0;
            overflow_d  = 1'b0;
            state_d     = (bus.entities_number == 8'd0) ? DONE : FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            line_y_q    <= 9'd0;
            count_q     <= 8'd0;
            addr_q      <= 8'd0;
            hit_valid_q <= 1'b0;
            hit_data_q  <= 21'd0;
            hit_count_q <= 5'd0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_y_q    <= line_y_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            hit_valid_q <= hit_valid_d;
            hit_data_q  <= hit_data_d;
            hit_count_q <= hit_count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.address_read_ent = addr_q;
    assign bus.hit_valid        = hit_valid_q;
    assign bus.hit_data         = hit_data_q;
    assign bus.hit_count        = hit_count_q;
    assign bus.overflow         = overflow_q;
    assign bus.scan_busy        = (state_q == FETCH) || (state_q == EVAL) || (state_q == WAIT);
    assign bus.scan_done        = (state_q == DONE);
endmodule

// File: tb/tb_entity_line_scanner.sv
// Directed bench for entity_line_scanner. It uses a registered-read entity table model.
// A second instance with MAX_HITS=4 exercises saturation.
module tb_entity_line_scanner;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    entity_line_scanner_if bus ();
    entity_line_scanner_if bus4 ();

    entity_line_scanner #(.SIZE(48), .MAX_HITS(16)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    entity_line_scanner #(.SIZE(48), .MAX_HITS(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4.slave)
    );

    logic [20:0] ent_mem [0:255];
    always @(posedge clk) begin
        bus.data_read_ent  <= ent_mem[bus.address_read_ent];
        bus4.data_read_ent <= ent_mem[bus4.address_read_ent];
    end

    logic [20:0] hits_q [$];
    logic [20:0] hits4_q [$];
    int done_cnt = 0;
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.hit_valid && bus.hit_ready) begin
                hits_q.push_back(bus.hit_data);
                $display("hit  addr=%0d data=%h", bus.address_read_ent, bus.hit_data);
            end
            if (bus4.hit_valid && bus4.hit_ready) hits4_q.push_back(bus4.hit_data);
            if (bus.scan_done) done_cnt <= done_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    function automatic logic [20:0] grid_entry(input int i);
        logic [2:0] t;
        logic [8:0] x;
        logic [8:0] y;
        t = 3'((i % 7) + 1);
        x = 9'((i / 10) * 40);
        y = 9'((i % 10) * 48);
        return {t, x, y};
    endfunction

    task automatic load_grid();
        for (int i = 0; i < 256; i++) ent_mem[i] = (i < 114) ? grid_entry(i) : 21'd0;
    endtask

    task automatic start_scan(input logic [8:0] ly, input logic [7:0] n);
        @(negedge clk);
        bus.line_y = ly;
        bus.entities_number = n;
        bus.line_start = 1'b1;
        @(negedge clk);
        bus.line_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output int cycles, output bit timed_out);
        cycles = 1;
        timed_out = 1'b0;
        while (!bus.scan_done) begin
            if (cycles >= max_cycles) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.address_read_ent, bus.hit_valid, bus.hit_data, bus.scan_busy, bus.scan_done,
             bus.hit_count, bus.overflow} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: addr=%0d hv=%b hd=%h busy=%b done=%b cnt=%0d ovf=%b, required all 0",
                     bus.address_read_ent, bus.hit_valid, bus.hit_data, bus.scan_busy,
                     bus.scan_done, bus.hit_count, bus.overflow);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.scan_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b required 0", bus.scan_busy);
        end
        $display("reset checked");
    endtask

    task automatic test_grid_scan();
        int cyc;
        bit to;
        int base;
        load_grid();
        bus.hit_ready = 1'b1;
        base = hits_q.size();
        start_scan(9'd100, 8'd114);
        wait_done(400, cyc, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL grid_timeout: got %b required 0", to); end
        n_checks++;
        if (cyc != 229) begin n_fail++; $display("FAIL grid_latency: got %0d required 229", cyc); end
        n_checks++;
        if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL grid_overflow: got %b required 0", bus.overflow); end
        n_checks++;
        if (bus.hit_count !== 5'd12) begin n_fail++; $display("FAIL grid_hit_count: got %0d required 12", bus.hit_count); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (hits_q.size() - base != 12) begin
            n_fail++;
            $display("FAIL grid_num_hits: got %0d required 12", hits_q.size() - base);
        end
        for (int k = 0; k < 12 && base + k < hits_q.size(); k++) begin
            n_checks++;
            if (hits_q[base + k] !== grid_entry(10 * k + 2)) begin
                n_fail++;
                $display("FAIL grid_hit_%0d: got %h required %h", k, hits_q[base + k], grid_entry(10 * k + 2));
            end
        end
        $display("grid scan line_y=100 cycles=%0d", cyc);
    endtask

    task automatic test_backpressure();
        int cyc;
        bit to;
        int base;
        int unstable;
        logic [20:0] first;
        load_grid();
        bus.hit_ready = 1'b0;
        base = hits_q.size();
        first = grid_entry(0);
        start_scan(9'd47, 8'd114);
        cyc = 0;
        while (!bus.hit_valid && cyc < 20) begin @(negedge clk); cyc++; end
        n_checks++;
        if (bus.hit_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b required 1", bus.hit_valid); end
        unstable = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.hit_data !== first || bus.hit_valid !== 1'b1) unstable++;
        end
        n_checks++;
        if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable cycles, required 0", unstable); end
        n_checks++;
        if (bus.address_read_ent !== 8'd10) begin n_fail++; $display("FAIL bp_wait_addr: got %0d required 10", bus.address_read_ent); end
        n_checks++;
        if (bus.scan_busy !== 1'b1) begin n_fail++; $display("FAIL bp_wait_busy: got %b required 1", bus.scan_busy); end
        n_checks++;
        if (bus.hit_count !== 5'd1) begin n_fail++; $display("FAIL bp_wait_count: got %0d required 1", bus.hit_count); end
        bus.hit_ready = 1'b1;
        wait_done(400, cyc, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %b required 0", to); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (hits_q.size() - base != 12) begin n_fail++; $display("FAIL bp_num_hits: got %0d required 12", hits_q.size() - base); end
        for (int k = 0; k < 12 && base + k < hits_q.size(); k++) begin
            n_checks++;
            if (hits_q[base + k] !== grid_entry(10 * k)) begin
                n_fail++;
                $display("FAIL bp_hit_%0d: got %h required %h", k, hits_q[base + k], grid_entry(10 * k));
            end
        end
        $display("backpressure scan line_y=47 done");
    endtask

    task automatic test_boundary();
        logic [8:0] ys  [6] = '{9'd0, 9'd0, 9'd0, 9'd432, 9'd500, 9'd100};
        logic [8:0] lys [6] = '{9'd0, 9'd47, 9'd48, 9'd479, 9'd510, 9'd99};
        int exp_n [6] = '{1, 1, 0, 1, 1, 0};
        int cyc;
        bit to;
        int base;
        int got_n;
        logic [20:0] word;
        bus.hit_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            word = {3'd5, 9'd300, ys[c]};
            ent_mem[0] = word;
            base = hits_q.size();
            start_scan(lys[c], 8'd1);
            wait_done(10, cyc, to);
            repeat (3) @(negedge clk);
            got_n = hits_q.size() - base;
            n_checks++;
            if (to !== 1'b0 || got_n != exp_n[c]) begin
                n_fail++;
                $display("FAIL boundary_y%0d_line%0d: got %0d hits (timeout=%b) required %0d",
                         ys[c], lys[c], got_n, to, exp_n[c]);
            end else if (got_n == 1) begin
                n_checks++;
                if (hits_q[base] !== word) begin
                    n_fail++;
                    $display("FAIL boundary_data_%0d: got %h required %h", c, hits_q[base], word);
                end
            end
            $display("boundary y=%0d line_y=%0d hits=%0d", ys[c], lys[c], got_n);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        int base;
        for (int i = 0; i < 10; i++) ent_mem[i] = {3'd2, 9'(i * 10), 9'd0};
        bus4.hit_ready = 1'b1;
        base = hits4_q.size();
        @(negedge clk);
        bus4.line_y = 9'd10;
        bus4.entities_number = 8'd10;
        bus4.line_start = 1'b1;
        @(negedge clk);
        bus4.line_start = 1'b0;
        cyc = 1;
        while (!bus4.scan_done && cyc < 50) begin @(negedge clk); cyc++; end
        n_checks++;
        if (bus4.scan_done !== 1'b1) begin n_fail++; $display("FAIL ovf_timeout: scan_done=%b required 1", bus4.scan_done); end
        n_checks++;
        if (bus4.hit_count !== 5'd4) begin n_fail++; $display("FAIL ovf_hit_count: got %0d required 4", bus4.hit_count); end
        n_checks++;
        if (bus4.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b required 1", bus4.overflow); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (hits4_q.size() - base != 4) begin n_fail++; $display("FAIL ovf_handshakes: got %0d required 4", hits4_q.size() - base); end
        for (int k = 0; k < 4 && base + k < hits4_q.size(); k++) begin
            n_checks++;
            if (hits4_q[base + k] !== {3'd2, 9'(k * 10), 9'd0}) begin
                n_fail++;
                $display("FAIL ovf_hit_%0d: got %h required %h", k, hits4_q[base + k], {3'd2, 9'(k * 10), 9'd0});
            end
        end
        $display("overflow scan MAX_HITS=4 handshakes=%0d", hits4_q.size() - base);
    endtask

    task automatic test_abort();
        int cyc;
        bit to;
        int base;
        int dbase;
        load_grid();
        bus.hit_ready = 1'b1;
        start_scan(9'd47, 8'd114);
        cyc = 0;
        while (bus.address_read_ent != 8'd30 && cyc < 100) begin @(negedge clk); cyc++; end
        bus.hit_ready = 1'b0;
        cyc = 0;
        while (!bus.hit_valid && cyc < 5) begin @(negedge clk); cyc++; end
        n_checks++;
        if (bus.hit_valid !== 1'b1 || bus.hit_data !== grid_entry(30)) begin
            n_fail++;
            $display("FAIL abort_pending_hit: valid=%b data=%h required 1 and %h", bus.hit_valid, bus.hit_data, grid_entry(30));
        end
        base = hits_q.size();
        dbase = done_cnt;
        start_scan(9'd100, 8'd114);
        n_checks++;
        if (bus.hit_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid_cleared: got %b required 0", bus.hit_valid); end
        n_checks++;
        if (bus.address_read_ent !== 8'd0) begin n_fail++; $display("FAIL abort_addr: got %0d required 0", bus.address_read_ent); end
        bus.hit_ready = 1'b1;
        wait_done(400, cyc, to);
        n_checks++;
        if (to !== 1'b0 || cyc != 229) begin n_fail++; $display("FAIL abort_rescan_latency: got %0d (timeout=%b) required 229", cyc, to); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt - dbase != 1) begin n_fail++; $display("FAIL abort_done_pulses: got %0d required 1", done_cnt - dbase); end
        n_checks++;
        if (hits_q.size() - base != 12) begin n_fail++; $display("FAIL abort_num_hits: got %0d required 12", hits_q.size() - base); end
        else begin
            n_checks++;
            if (hits_q[base] !== grid_entry(2)) begin n_fail++; $display("FAIL abort_first_hit: got %h required %h", hits_q[base], grid_entry(2)); end
        end
        $display("abort at entry 30 then rescan line_y=100 cycles=%0d", cyc);

        base = hits_q.size();
        dbase = done_cnt;
        start_scan(9'd5, 8'd0);
        n_checks++;
        if (bus.scan_done !== 1'b1) begin n_fail++; $display("FAIL empty_done: got %b required 1", bus.scan_done); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (hits_q.size() != base || done_cnt - dbase != 1 || bus.hit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_scan: hits=%0d dones=%0d valid=%b required 0,1,0", hits_q.size() - base, done_cnt - dbase, bus.hit_valid);
        end
        $display("empty table scan done");
    endtask

    task automatic test_reset_in_wait();
        int cyc;
        load_grid();
        bus.hit_ready = 1'b0;
        start_scan(9'd47, 8'd114);
        cyc = 0;
        while (bus.address_read_ent != 8'd10 && cyc < 60) begin @(negedge clk); cyc++; end
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.hit_valid !== 1'b1 || bus.scan_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstwait_pre: valid=%b busy=%b required 1,1", bus.hit_valid, bus.scan_busy);
        end
        rst = 1'b1;
        bus.line_start = 1'b1;
        bus.line_y = 9'd47;
        bus.entities_number = 8'd114;
        @(negedge clk);
        n_checks++;
        if ({bus.address_read_ent, bus.hit_valid, bus.hit_data, bus.scan_busy, bus.scan_done,
             bus.hit_count, bus.overflow} !== 38'd0) begin
            n_fail++;
            $display("FAIL rstwait_outputs: addr=%0d hv=%b hd=%h busy=%b done=%b cnt=%0d ovf=%b, required all 0",
                     bus.address_read_ent, bus.hit_valid, bus.hit_data, bus.scan_busy,
                     bus.scan_done, bus.hit_count, bus.overflow);
        end
        n_checks++;
        if (bus4.overflow !== 1'b0 || bus4.hit_count !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_clears_overflow: ovf=%b cnt=%0d required 0,0", bus4.overflow, bus4.hit_count);
        end
        bus.line_start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.scan_busy !== 1'b0) begin n_fail++; $display("FAIL rst_overrides_start: busy=%b required 0", bus.scan_busy); end
        $display("reset during WAIT checked");
    endtask

    initial begin
        rst = 1'b1;
        bus.line_start = 1'b0;
        bus.line_y = 9'd0;
        bus.entities_number = 8'd0;
        bus.hit_ready = 1'b0;
        bus4.line_start = 1'b0;
        bus4.line_y = 9'd0;
        bus4.entities_number = 8'd0;
        bus4.hit_ready = 1'b0;
        for (int i = 0; i < 256; i++) ent_mem[i] = 21'd0;
        test_reset();
        test_grid_scan();
        test_backpressure();
        test_boundary();
        test_overflow();
        test_abort();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
